// File: rtl/snn_core_pkg.sv
// Shared types and width helpers for the neuron core scheduler slice.
package snn_core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INIT,
      INTEGRATE,
      FIRE,
      WAIT_SPK,
      DONE
   } sched_state_t;

   localparam int unsigned AXON_TYPE_W = 2;

   function automatic int unsigned neuron_idx_w(input int unsigned num_neurons);
      return (num_neurons > 1) ? $clog2(num_neurons) : 1;
   endfunction

   function automatic int unsigned axon_idx_w(input int unsigned num_axons);
      return (num_axons > 1) ? $clog2(num_axons) : 1;
   endfunction

endpackage

// File: rtl/axon_priority_encoder.sv
// Lowest-index-first priority encoder over the active-axon mask.
module axon_priority_encoder
   import snn_core_pkg::*;
#(
   parameter int unsigned NUM_AXONS = 256
) (
   input  logic [NUM_AXONS-1:0]                req,
   output logic [axon_idx_w(NUM_AXONS)-1:0]    index,
   output logic                                any
);

   localparam int unsigned AW = axon_idx_w(NUM_AXONS);

   // Scan downward so the lowest set bit is the last assignment to win.
   always_comb begin
      index = '0;
      any   = |req;
      for (int i = int'(NUM_AXONS) - 1; i >= 0; i--) begin
         if (req[i]) index = AW'(i);
      end
   end

endmodule

// File: rtl/neuron_core_scheduler.sv
// Per-tick sequencer for the shared neuron_block: walks neurons and axons, writes back, pushes spikes.
// Optional SCHED_SKIP_ZERO_AXON_EN: integrate only axons with spike & connectivity set.
module neuron_core_scheduler
   import snn_core_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 256,
   parameter int unsigned NUM_AXONS   = 256
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  tick_start,
   input  logic [NUM_AXONS-1:0]                  axon_spikes,
   input  logic [AXON_TYPE_W*NUM_AXONS-1:0]      axon_types,
   output logic                                  busy,
   output logic                                  tick_done,
   output logic [neuron_idx_w(NUM_NEURONS)-1:0]  mem_addr,
   output logic                                  mem_rd_en,
   output logic                                  mem_wr_en,
   input  logic [NUM_AXONS-1:0]                  syn_row,
   output logic                                  new_neuron,
   output logic                                  process_spike,
   output logic                                  reg_en,
   output logic [AXON_TYPE_W-1:0]                neuron_instruction,
   input  logic                                  nb_spike,
   output logic                                  spk_valid,
   input  logic                                  spk_ready,
   output logic [neuron_idx_w(NUM_NEURONS)-1:0]  spk_neuron_id
);

   localparam int unsigned NW = neuron_idx_w(NUM_NEURONS);
   localparam int unsigned AW = axon_idx_w(NUM_AXONS);
   localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

   sched_state_t         state_q, state_d;
   logic [NW-1:0]        n_q, n_d;
   logic [NUM_AXONS-1:0] spk_lat_q, spk_lat_d;
   logic [AW-1:0]        cur_axon;
   logic                 cur_active;
   logic                 init_has_work;
   logic                 integ_last;
   logic                 adv;

`ifdef SCHED_SKIP_ZERO_AXON_EN
   logic [NUM_AXONS-1:0] pend_q, pend_d, pend_clr;
   logic                 pick_any;

   axon_priority_encoder #(
      .NUM_AXONS (NUM_AXONS)
   ) u_axon_pe (
      .req   (pend_q),
      .index (cur_axon),
      .any   (pick_any)
   );

   always_comb begin
      pend_clr           = pend_q;
      pend_clr[cur_axon] = 1'b0;
   end

   assign init_has_work = |(spk_lat_q & syn_row);
   assign integ_last    = ~|pend_clr;
   assign cur_active    = pick_any;

   // Pending mask: loaded from spike & row in INIT, one bit retired per INTEGRATE cycle.
   always_comb begin
      pend_d = pend_q;
      if (state_q == INIT) begin
         pend_d = spk_lat_q & syn_row;
      end else if (state_q == INTEGRATE) begin
         pend_d = pend_clr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end
`else
   localparam logic [AW-1:0] A_LAST = AW'(NUM_AXONS - 1);

   logic [AW-1:0]        a_q, a_d;
   logic [NUM_AXONS-1:0] row_lat_q, row_lat_d;

   assign cur_axon      = a_q;
   assign cur_active    = spk_lat_q[a_q] & row_lat_q[a_q];
   assign init_has_work = 1'b1;
   assign integ_last    = (a_q == A_LAST);

   always_comb begin
      a_d       = a_q;
      row_lat_d = row_lat_q;
      if (state_q == INIT) begin
         row_lat_d = syn_row;
         a_d       = '0;
      end else if (state_q == INTEGRATE && !integ_last) begin
         a_d = a_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q       <= '0;
         row_lat_q <= '0;
      end else begin
         a_q       <= a_d;
         row_lat_q <= row_lat_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         n_q       <= '0;
         spk_lat_q <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         spk_lat_q <= spk_lat_d;
      end
   end

   // Leave FIRE/WAIT_SPK once no spike is owed downstream or the push completes.
   assign adv = ((state_q == FIRE) && !(nb_spike && !spk_ready)) ||
                ((state_q == WAIT_SPK) && spk_ready);

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      spk_lat_d = spk_lat_q;
      unique case (state_q)
         IDLE: begin
            if (tick_start) begin
               state_d   = LOAD;
               n_d       = '0;
               spk_lat_d = axon_spikes;
            end
         end
         LOAD:      state_d = INIT;
         INIT:      state_d = init_has_work ? INTEGRATE : FIRE;
         INTEGRATE: if (integ_last) state_d = FIRE;
         FIRE:      if (!adv) state_d = WAIT_SPK;
         WAIT_SPK:  state_d = WAIT_SPK;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (adv) begin
         if (n_q == N_LAST) begin
            state_d = DONE;
         end else begin
            state_d = LOAD;
            n_d     = n_q + NW'(1);
         end
      end
   end

   always_comb begin
      busy               = (state_q != IDLE) && (state_q != DONE);
      tick_done          = 1'b0;
      mem_addr           = '0;
      mem_rd_en          = 1'b0;
      mem_wr_en          = 1'b0;
      new_neuron         = 1'b0;
      process_spike      = 1'b0;
      reg_en             = 1'b0;
      neuron_instruction = '0;
      spk_valid          = 1'b0;
      spk_neuron_id      = '0;
      unique case (state_q)
         LOAD: begin
            mem_addr  = n_q;
            mem_rd_en = 1'b1;
         end
         INIT: new_neuron = 1'b1;
         INTEGRATE: begin
            reg_en             = 1'b1;
            process_spike      = cur_active;
            neuron_instruction = axon_types[AXON_TYPE_W*cur_axon +: AXON_TYPE_W];
         end
         FIRE: begin
            mem_addr      = n_q;
            mem_wr_en     = 1'b1;
            spk_valid     = nb_spike;
            spk_neuron_id = nb_spike ? n_q : '0;
         end
         WAIT_SPK: begin
            spk_valid     = 1'b1;
            spk_neuron_id = n_q;
         end
         DONE: tick_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_neuron_core_scheduler.sv
// Bench for neuron_core_scheduler with neuron_block and state-RAM models, 4 neurons x 4 axons.
module tb_neuron_core_scheduler;

   localparam int N    = 4;
   localparam int A    = 4;
   localparam int LEAK = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       tick_start = 1'b0;
   logic [3:0] axon_spikes = '0;
   logic [7:0] axon_types = '0;
   logic       busy, tick_done, mem_rd_en, mem_wr_en;
   logic [1:0] mem_addr, spk_neuron_id, neuron_instruction;
   logic [3:0] syn_row = '0;
   logic       new_neuron, process_spike, reg_en, nb_spike, spk_valid;
   logic       spk_ready = 1'b1;

   always #5 clk = ~clk;

   neuron_core_scheduler #(
      .NUM_NEURONS (N),
      .NUM_AXONS   (A)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .tick_start         (tick_start),
      .axon_spikes        (axon_spikes),
      .axon_types         (axon_types),
      .busy               (busy),
      .tick_done          (tick_done),
      .mem_addr           (mem_addr),
      .mem_rd_en          (mem_rd_en),
      .mem_wr_en          (mem_wr_en),
      .syn_row            (syn_row),
      .new_neuron         (new_neuron),
      .process_spike      (process_spike),
      .reg_en             (reg_en),
      .neuron_instruction (neuron_instruction),
      .nb_spike           (nb_spike),
      .spk_valid          (spk_valid),
      .spk_ready          (spk_ready),
      .spk_neuron_id      (spk_neuron_id)
   );

   int total = 0;
   int bad = 0;

   // State RAM and neuron_block models
   int         pot_mem[N];
   int         init_pot[N];
   int         thr_mem[N];
   logic [3:0] syn_mem[N];
   bit         ram_load = 0;
   int         rd_pot = 0;
   int         rd_thr = 0;
   int         nb_pot = 0;
   int         pot_out;

   function automatic int leak_fn(input int p);
      return (p > LEAK) ? p - LEAK : 0;
   endfunction

   assign nb_spike = (nb_pot >= rd_thr);
   assign pot_out  = nb_spike ? 0 : nb_pot;

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < N; i++) pot_mem[i] <= init_pot[i];
      end else if (mem_wr_en) begin
         pot_mem[mem_addr] <= pot_out;
      end
      if (mem_rd_en) begin
         rd_pot  <= pot_mem[mem_addr];
         rd_thr  <= thr_mem[mem_addr];
         syn_row <= syn_mem[mem_addr];
      end
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) nb_pot <= 0;
      else if (new_neuron) nb_pot <= leak_fn(rd_pot);
      else if (reg_en && process_spike) nb_pot <= nb_pot + int'(neuron_instruction) + 1;
   end

   // Scoreboards and monitor
   int         sb_id[$];
   logic [2:0] sb_int[$];
   bit         chk_int = 0;
   int         wr_cnt = 0, done_cnt = 0, reg_cnt = 0, push_cnt = 0;
   logic       prev_vs = 1'b0;
   logic [1:0] prev_id = '0;
   int         exp_pot[N];
   int         exp_lat;
   wire [13:0] all_out = {busy, tick_done, mem_addr, mem_rd_en, mem_wr_en, new_neuron,
                          process_spike, reg_en, neuron_instruction, spk_valid, spk_neuron_id};

   always @(negedge clk) begin
      int         e;
      logic [2:0] ei;
      if (!reset_n) begin
         prev_vs = 1'b0;
      end else begin
         if (mem_wr_en) wr_cnt++;
         if (tick_done) done_cnt++;
         if (reg_en) reg_cnt++;
         if (!reg_en) begin
            total++;
            if (process_spike !== 1'b0 || neuron_instruction !== 2'd0) begin
               bad++;
               $display("FAIL nb_ctrl_idle got ps=%b instr=%0d exp 0/0", process_spike,
                        neuron_instruction);
            end
         end
         if (chk_int && reg_en) begin
            total++;
            if (sb_int.size() == 0) begin
               bad++;
               $display("FAIL instr_extra got %b exp none", {process_spike, neuron_instruction});
            end else begin
               ei = sb_int.pop_front();
               if ({process_spike, neuron_instruction} !== ei) begin
                  bad++;
                  $display("FAIL instr_seq got %b exp %b", {process_spike, neuron_instruction}, ei);
               end
            end
         end
         if (prev_vs) begin
            total++;
            if (spk_valid !== 1'b1 || spk_neuron_id !== prev_id) begin
               bad++;
               $display("FAIL spk_hold got v=%b id=%0d exp v=1 id=%0d", spk_valid, spk_neuron_id,
                        prev_id);
            end
         end
         if (spk_valid && spk_ready) begin
            push_cnt++;
            total++;
            if (sb_id.size() == 0) begin
               bad++;
               $display("FAIL spk_extra got id=%0d exp none", spk_neuron_id);
            end else begin
               e = sb_id.pop_front();
               if (int'(spk_neuron_id) !== e) begin
                  bad++;
                  $display("FAIL spk_id got %0d exp %0d", spk_neuron_id, e);
               end
            end
         end
         prev_vs = spk_valid && !spk_ready;
         prev_id = spk_neuron_id;
      end
   end

   task automatic commit_ram();
      @(posedge clk); #1 ram_load = 1;
      @(posedge clk); #1 ram_load = 0;
   endtask

   // Reference: expected potentials, spike pushes, instruction stream and latency.
   task automatic prep_expect(input logic [3:0] spikes, input bit with_int);
      logic [3:0] act;
      logic [7:0] tv;
      logic [1:0] ty;
      int         p;
      tv      = axon_types;
      exp_lat = 1;
      for (int n = 0; n < N; n++) begin
         act = spikes & syn_mem[n];
         p   = leak_fn(init_pot[n]);
`ifdef SCHED_SKIP_ZERO_AXON_EN
         exp_lat += 3;
`else
         exp_lat += 3 + A;
`endif
         for (int a = 0; a < A; a++) begin
            ty = tv[2*a +: 2];
            if (act[a]) p += int'(ty) + 1;
`ifdef SCHED_SKIP_ZERO_AXON_EN
            if (act[a]) begin
               exp_lat++;
               if (with_int) sb_int.push_back({1'b1, ty});
            end
`else
            if (with_int) sb_int.push_back({act[a], ty});
`endif
         end
         if (p >= thr_mem[n]) begin
            exp_pot[n] = 0;
            sb_id.push_back(n);
         end else begin
            exp_pot[n] = p;
         end
      end
   endtask

   // Starts a tick and waits (bounded) for tick_done; cyc=-1 on timeout.
   task automatic run_tick(input logic [3:0] spikes, input int stall, input int poke,
                           output int cyc, output int stalled);
      bit done;
      bit raise;
      @(posedge clk); #1;
      axon_spikes = spikes;
      tick_start  = 1'b1;
      if (stall > 0) spk_ready = 1'b0;
      @(posedge clk); #1;
      tick_start = 1'b0;
      cyc = 0; stalled = 0; done = 0;
      while (!done && cyc < 400) begin
         cyc++;
         raise = 0;
         @(negedge clk);
         if (tick_done) begin
            done = 1;
         end else begin
            if (spk_valid && !spk_ready) begin
               stalled++;
               if (stalled >= stall) raise = 1;
            end
            @(posedge clk); #1;
            if (raise) spk_ready = 1'b1;
            tick_start = (cyc + 1 == poke);
            if (cyc + 1 == poke) axon_spikes = ~spikes;
         end
      end
      tick_start = 1'b0;
      if (!done) cyc = -1;
   endtask

   task automatic check_pots(input string tag);
      for (int i = 0; i < N; i++) begin
         total++;
         if (pot_mem[i] !== exp_pot[i]) begin
            bad++;
            $display("FAIL %s_pot%0d got %0d exp %0d", tag, i, pot_mem[i], exp_pot[i]);
         end
      end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if (all_out !== 14'd0) begin
         bad++;
         $display("FAIL reset_outputs got %b exp 0", all_out);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (all_out !== 14'd0) begin
         bad++;
         $display("FAIL idle_after_reset got %b exp 0", all_out);
      end
   endtask

   task automatic test_reset_mid_tick();
      int w0, d0, w1;
      init_pot = '{7, 7, 7, 7};
      thr_mem  = '{100, 100, 100, 100};
      syn_mem  = '{4'hF, 4'hF, 4'hF, 4'hF};
      axon_types = 8'b11_10_01_00;
      commit_ram();
      prep_expect(4'hF, 1'b0);
      exp_pot[2] = 7;
      exp_pot[3] = 7;
      w0 = wr_cnt; d0 = done_cnt;
      @(posedge clk); #1 axon_spikes = 4'hF; tick_start = 1'b1;
      @(posedge clk); #1 tick_start = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (reg_en !== 1'b1 || wr_cnt - w0 != 2) begin
         bad++;
         $display("FAIL mid_integrate got reg_en=%b writes=%0d exp 1/2", reg_en, wr_cnt - w0);
      end
      #1 reset_n = 1'b0;
      @(negedge clk);
      total++;
      if (all_out !== 14'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs got %b exp 0", all_out);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      w1 = wr_cnt;
      repeat (40) @(negedge clk);
      total++;
      if (wr_cnt != w1 || done_cnt != d0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_after got wr=%0d done=%0d busy=%b exp 0/0/0", wr_cnt - w1,
                  done_cnt - d0, busy);
      end
      check_pots("reset_mid");
   endtask

   task automatic test_leak_only();
      int cyc, st, w0, p0;
      init_pot = '{5, 5, 5, 5};
      thr_mem  = '{100, 100, 100, 100};
      syn_mem  = '{4'hF, 4'hF, 4'hF, 4'hF};
      axon_types = 8'b11_10_01_00;
      commit_ram();
      prep_expect(4'h0, 1'b0);
      w0 = wr_cnt; p0 = push_cnt;
      run_tick(4'h0, 0, 0, cyc, st);
      total++;
      if (cyc != exp_lat) begin
         bad++;
         $display("FAIL leak_latency got %0d exp %0d", cyc, exp_lat);
      end
`ifndef SCHED_SKIP_ZERO_AXON_EN
      total++;
      if (cyc != 29) begin
         bad++;
         $display("FAIL leak_latency29 got %0d exp 29", cyc);
      end
`endif
      total++;
      if (wr_cnt - w0 != 4 || push_cnt != p0) begin
         bad++;
         $display("FAIL leak_writes got wr=%0d push=%0d exp 4/0", wr_cnt - w0, push_cnt - p0);
      end
      check_pots("leak");
   endtask

   task automatic test_full_integrate();
      int cyc, st, p0;
      init_pot = '{0, 5, 10, 20};
      thr_mem  = '{8, 20, 15, 25};
      syn_mem  = '{4'hF, 4'hF, 4'hF, 4'hF};
      axon_types = 8'b11_10_01_00;
      commit_ram();
      chk_int = 1;
      prep_expect(4'hF, 1'b1);
      p0 = push_cnt;
      run_tick(4'hF, 0, 0, cyc, st);
      @(negedge clk);
      chk_int = 0;
      total++;
      if (cyc != exp_lat || push_cnt - p0 != 3) begin
         bad++;
         $display("FAIL full_tick got lat=%0d push=%0d exp %0d/3", cyc, push_cnt - p0, exp_lat);
      end
      total++;
      if (sb_id.size() != 0 || sb_int.size() != 0) begin
         bad++;
         $display("FAIL full_leftover got ids=%0d instr=%0d exp 0/0", sb_id.size(), sb_int.size());
      end
      check_pots("full");
   endtask

   task automatic test_backpressure();
      int cyc, st, p0;
      init_pot = '{0, 0, 0, 0};
      thr_mem  = '{50, 5, 50, 5};
      syn_mem  = '{4'hF, 4'hF, 4'hF, 4'hF};
      axon_types = 8'b11_10_01_00;
      commit_ram();
      prep_expect(4'hF, 1'b0);
      p0 = push_cnt;
      run_tick(4'hF, 5, 0, cyc, st);
      total++;
      if (st != 5 || cyc != exp_lat + 5) begin
         bad++;
         $display("FAIL bp_stall got stall=%0d lat=%0d exp 5/%0d", st, cyc, exp_lat + 5);
      end
      total++;
      if (push_cnt - p0 != 2 || sb_id.size() != 0) begin
         bad++;
         $display("FAIL bp_pushes got %0d left=%0d exp 2/0", push_cnt - p0, sb_id.size());
      end
      check_pots("bp");
   endtask

   task automatic test_busy_ignore();
      int cyc, st, d0;
      init_pot = '{5, 5, 5, 5};
      thr_mem  = '{100, 100, 100, 100};
      syn_mem  = '{4'hF, 4'h7, 4'hF, 4'h1};
      axon_types = 8'b00_11_01_10;
      commit_ram();
      prep_expect(4'b0101, 1'b0);
      d0 = done_cnt;
      run_tick(4'b0101, 0, 10, cyc, st);
      total++;
      if (cyc != exp_lat) begin
         bad++;
         $display("FAIL busy_latency got %0d exp %0d", cyc, exp_lat);
      end
      repeat (40) @(negedge clk);
      total++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_done_count got %0d busy=%b exp 1/0", done_cnt - d0, busy);
      end
      check_pots("busy");
   endtask

`ifdef SCHED_SKIP_ZERO_AXON_EN
   task automatic test_skip();
      int cyc, st, r0;
      init_pot = '{3, 3, 3, 3};
      thr_mem  = '{100, 100, 100, 100};
      syn_mem  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
      axon_types = 8'b11_10_01_00;
      commit_ram();
      prep_expect(4'b0100, 1'b0);
      r0 = reg_cnt;
      run_tick(4'b0100, 0, 0, cyc, st);
      total++;
      if (reg_cnt - r0 != 1 || cyc != 14) begin
         bad++;
         $display("FAIL skip_cycles got reg=%0d lat=%0d exp 1/14", reg_cnt - r0, cyc);
      end
      check_pots("skip");
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_tick();
      test_leak_only();
      test_full_integrate();
      test_backpressure();
      test_busy_ignore();
`ifdef SCHED_SKIP_ZERO_AXON_EN
      test_skip();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
